// File: rtl/ccff_shadow_mem.sv
// ccff_shadow_mem
//
// Configuration-chain memory frame for one routing mux or LUT. Config bits
// shift in serially on ccff_head while ccff_en is high. The last stage drives
// ccff_tail, so several frames can be chained. The fabric sees a separate
// shadow register. That register changes only when a commit is accepted, so
// mux selects stay glitch-free while the chain is being programmed.
//
// Parameters
//   MEM_SIZE   number of config bits in this frame (>= 1)
//   RESET_VAL  reset value for the shift and shadow registers; bit i maps to
//              index i of sr / mem_out
//
// Ports
//   prog_clk    programming clock; all state updates on the rising edge
//   prog_reset  synchronous reset, active-high; overrides every other input
//   ccff_head   serial config data in
//   ccff_en     shift enable; one bit moves per enabled cycle
//   commit      request to copy the shift register into the shadow register
//   ccff_tail   serial data out, driven from the last shift stage
//   mem_out     shadow config bits to the fabric, indexed [0:MEM_SIZE-1]
//   mem_outb    bitwise complement of mem_out
//   frame_full  high once MEM_SIZE bits have been shifted since reset/commit
//   shift_cnt   bits shifted since reset/last accepted commit, saturating
//   commit_err  one-cycle pulse after a commit was rejected (frame not full)
//
// Every output comes from a register or is decoded from registers only.
// There is no combinational path from any input to any output.

module ccff_shadow_mem #(
  parameter int unsigned               MEM_SIZE  = 3,
  parameter logic [MEM_SIZE-1:0]       RESET_VAL = '0,
  localparam int unsigned              CNT_W     = $clog2(MEM_SIZE + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                commit,
  output logic                ccff_tail,
  output logic [0:MEM_SIZE-1] mem_out,
  output logic [0:MEM_SIZE-1] mem_outb,
  output logic                frame_full,
  output logic [CNT_W-1:0]    shift_cnt,
  output logic                commit_err
);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:MEM_SIZE-1] sr_q,         sr_d;
  logic [0:MEM_SIZE-1] shadow_q,     shadow_d;
  logic [CNT_W-1:0]    shift_cnt_q,  shift_cnt_d;
  logic                commit_err_q, commit_err_d;

  // RESET_VAL is given LSB-first (bit i -> index i). A plain assignment to
  // an ascending range would reverse it, so the mapping is done bit by bit.
  logic [0:MEM_SIZE-1] reset_vec;

  always_comb begin
    reset_vec = '0;
    for (int i = 0; i < int'(MEM_SIZE); i++) begin
      reset_vec[i] = RESET_VAL[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Decodes on pre-edge state
  // ---------------------------------------------------------------------------
  logic full;
  logic commit_ok;
  logic commit_bad;

  assign full       = (shift_cnt_q == CntFull);
  assign commit_ok  = commit &&  full;
  assign commit_bad = commit && !full;

  // ---------------------------------------------------------------------------
  // Shift register: index 0 takes the new bit, so the first bit of a frame
  // ends up at index MEM_SIZE-1 after MEM_SIZE shifts.
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_d = sr_q;
    if (ccff_en) begin
      sr_d[0] = ccff_head;
      for (int i = 1; i < int'(MEM_SIZE); i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow register: takes the pre-shift contents of sr, so a commit that
  // lands together with a shift captures the completed frame rather than
  // the bit that is entering on this edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_q;
    if (commit_ok) begin
      shadow_d = sr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift counter: saturates at MEM_SIZE. Shifting goes on past full for
  // pass-through to downstream frames. An accepted commit starts a new frame.
  // A shift on the same edge counts as that frame's first bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (commit_ok) begin
      shift_cnt_d = ccff_en ? CntOne : '0;
    end else if (ccff_en && !full) begin
      shift_cnt_d = shift_cnt_q + CntOne;
    end
  end

  // Error flag: set only in the cycle after a rejected commit.
  always_comb begin
    commit_err_d = commit_bad;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sr_q         <= reset_vec;
      shadow_q     <= reset_vec;
      shift_cnt_q  <= '0;
      commit_err_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      shadow_q     <= shadow_d;
      shift_cnt_q  <= shift_cnt_d;
      commit_err_q <= commit_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ccff_tail  = sr_q[MEM_SIZE-1];
  assign mem_out    = shadow_q;
  assign mem_outb   = ~shadow_q;
  assign frame_full = full;
  assign shift_cnt  = shift_cnt_q;
  assign commit_err = commit_err_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      assert (shift_cnt_q <= CntFull)
        else $error("shift_cnt beyond frame size");
      assert (mem_outb == ~mem_out)
        else $error("mem_outb not complement of mem_out");
    end
  end
`endif

endmodule

// File: tb/tb_ccff_shadow_mem.sv
// Directed bench for ccff_shadow_mem. Three instances (MEM_SIZE 3, 1, 9)
// share one set of inputs. Each phase starts with a reset and checks one
// instance. The stimulus pushes hand-computed post-edge expectations into a
// queue. A monitor pops one entry per clock and compares it against the
// selected instance.

module tb_ccff_shadow_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic prog_reset = 1'b1;
  logic ccff_head  = 1'b0;
  logic ccff_en    = 1'b0;
  logic commit     = 1'b0;

  // MEM_SIZE = 3, RESET_VAL = 0
  logic       tail3, full3, err3;
  logic [0:2] mem3, memb3;
  logic [1:0] cnt3;
  // MEM_SIZE = 1, RESET_VAL = 1
  logic       tail1, full1, err1;
  logic [0:0] mem1, memb1;
  logic [0:0] cnt1;
  // MEM_SIZE = 9, RESET_VAL = 9'h103 (indices 0, 1, 8 set)
  logic       tail9, full9, err9;
  logic [0:8] mem9, memb9;
  logic [3:0] cnt9;

  ccff_shadow_mem #(.MEM_SIZE(3), .RESET_VAL(3'b000)) u_dut3 (
    .prog_clk(clk), .prog_reset(prog_reset), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .commit(commit), .ccff_tail(tail3), .mem_out(mem3),
    .mem_outb(memb3), .frame_full(full3), .shift_cnt(cnt3), .commit_err(err3)
  );

  ccff_shadow_mem #(.MEM_SIZE(1), .RESET_VAL(1'b1)) u_dut1 (
    .prog_clk(clk), .prog_reset(prog_reset), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .commit(commit), .ccff_tail(tail1), .mem_out(mem1),
    .mem_outb(memb1), .frame_full(full1), .shift_cnt(cnt1), .commit_err(err1)
  );

  ccff_shadow_mem #(.MEM_SIZE(9), .RESET_VAL(9'h103)) u_dut9 (
    .prog_clk(clk), .prog_reset(prog_reset), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .commit(commit), .ccff_tail(tail9), .mem_out(mem9),
    .mem_outb(memb9), .frame_full(full9), .shift_cnt(cnt9), .commit_err(err9)
  );

  typedef struct {
    int         dut;
    int         idx;
    logic       tail;
    logic [0:8] mem;   // index 0 leftmost, zero padded past MEM_SIZE
    int         cnt;
    logic       full;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;

  task automatic chk(input string name, input int dut, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d step%0d: got %0h expected %0h", name, dut, idx, act, exp);
  endtask

  // One clock of stimulus plus the state expected after that edge.
  task automatic step(input int dut, input logic rst, input logic en, input logic head,
                      input logic cmt, input logic tail, input logic [0:8] mem,
                      input int cnt, input logic full, input logic err);
    exp_t e;
    @(negedge clk);
    prog_reset = rst;
    ccff_en    = en;
    ccff_head  = head;
    commit     = cmt;
    step_no++;
    e.dut  = dut;  e.idx  = step_no; e.tail = tail; e.mem = mem;
    e.cnt  = cnt;  e.full = full;    e.err  = err;
    exp_q.push_back(e);
  endtask

  function automatic logic [0:8] m3(input logic [0:2] v);
    return {v, 6'b0};
  endfunction

  function automatic logic [0:8] m1(input logic v);
    return {v, 8'b0};
  endfunction

  task automatic s3(input logic rst, input logic en, input logic head, input logic cmt,
                    input logic tail, input logic [0:2] mem, input int cnt,
                    input logic full, input logic err);
    step(3, rst, en, head, cmt, tail, m3(mem), cnt, full, err);
  endtask

  task automatic s1(input logic rst, input logic en, input logic head, input logic cmt,
                    input logic tail, input logic mem, input int cnt,
                    input logic full, input logic err);
    step(1, rst, en, head, cmt, tail, m1(mem), cnt, full, err);
  endtask

  task automatic s9(input logic rst, input logic en, input logic head, input logic cmt,
                    input logic tail, input logic [0:8] mem, input int cnt,
                    input logic full, input logic err);
    step(9, rst, en, head, cmt, tail, mem, cnt, full, err);
  endtask

  // Monitor: compares the selected instance just after each rising edge.
  exp_t       me;
  logic       a_tail, a_full, a_err;
  logic [0:8] a_mem, a_memb, mask;
  int         a_cnt;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      case (me.dut)
        1: begin
          a_tail = tail1; a_mem = {mem1, 8'b0}; a_memb = {memb1, 8'b0};
          a_cnt = int'(cnt1); a_full = full1; a_err = err1; mask = 9'b100000000;
        end
        9: begin
          a_tail = tail9; a_mem = mem9; a_memb = memb9;
          a_cnt = int'(cnt9); a_full = full9; a_err = err9; mask = 9'b111111111;
        end
        default: begin
          a_tail = tail3; a_mem = {mem3, 6'b0}; a_memb = {memb3, 6'b0};
          a_cnt = int'(cnt3); a_full = full3; a_err = err3; mask = 9'b111000000;
        end
      endcase
      chk("ccff_tail",  me.dut, me.idx, 32'(a_tail), 32'(me.tail));
      chk("mem_out",    me.dut, me.idx, 32'(a_mem),  32'(me.mem));
      chk("mem_outb",   me.dut, me.idx, 32'(a_memb), 32'(~me.mem & mask));
      chk("shift_cnt",  me.dut, me.idx, 32'(a_cnt),  32'(me.cnt));
      chk("frame_full", me.dut, me.idx, 32'(a_full), 32'(me.full));
      chk("commit_err", me.dut, me.idx, 32'(a_err),  32'(me.err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic frame load and accepted commit.
    s3(1,0,0,0, 0,3'b000,0,0,0);
    s3(0,1,1,0, 0,3'b000,1,0,0);
    s3(0,1,1,0, 0,3'b000,2,0,0);
    s3(0,1,0,0, 1,3'b000,3,1,0);
    s3(0,0,0,1, 1,3'b011,0,0,0);
    // Early commit rejected, then accepted after one more shift.
    s3(0,1,1,0, 1,3'b011,1,0,0);
    s3(0,1,0,0, 0,3'b011,2,0,0);
    s3(0,0,0,1, 0,3'b011,2,0,1);
    s3(0,0,0,0, 0,3'b011,2,0,0);
    s3(0,1,1,0, 1,3'b011,3,1,0);
    s3(0,0,0,1, 1,3'b101,0,0,0);
    // Shifting past full: count saturates, tail keeps streaming.
    s3(1,0,0,0, 0,3'b000,0,0,0);
    s3(0,1,1,0, 0,3'b000,1,0,0);
    s3(0,1,0,0, 0,3'b000,2,0,0);
    s3(0,1,1,0, 1,3'b000,3,1,0);
    s3(0,1,1,0, 0,3'b000,3,1,0);
    s3(0,1,0,0, 1,3'b000,3,1,0);
    // Commit together with a shift: shadow gets the old frame, count restarts at 1.
    s3(0,1,1,0, 1,3'b000,3,1,0);
    s3(0,1,1,0, 0,3'b000,3,1,0);
    s3(0,1,1,0, 1,3'b000,3,1,0);
    s3(0,1,0,1, 1,3'b111,1,0,0);
    s3(0,0,0,1, 1,3'b111,1,0,1);
    s3(0,0,0,0, 1,3'b111,1,0,0);
    // Reset mid-frame overrides a simultaneous shift and commit.
    s3(0,1,1,0, 1,3'b111,2,0,0);
    s3(1,1,1,1, 0,3'b000,0,0,0);
    s3(0,0,0,1, 0,3'b000,0,0,1);
    s3(0,1,1,1, 0,3'b000,1,0,1);
    s3(0,0,0,0, 0,3'b000,1,0,0);
    // Enable gaps during a load.
    s3(1,0,0,0, 0,3'b000,0,0,0);
    s3(0,1,1,0, 0,3'b000,1,0,0);
    s3(0,0,0,0, 0,3'b000,1,0,0);
    s3(0,0,1,0, 0,3'b000,1,0,0);
    s3(0,1,0,0, 0,3'b000,2,0,0);
    s3(0,0,1,0, 0,3'b000,2,0,0);
    s3(0,1,1,0, 1,3'b000,3,1,0);
    s3(0,0,0,1, 1,3'b101,0,0,0);

    // Single-bit frame, reset value 1.
    s1(1,0,0,0, 1,1'b1,0,0,0);
    s1(0,0,0,1, 1,1'b1,0,0,1);
    s1(0,1,0,0, 0,1'b1,1,1,0);
    s1(0,0,1,0, 0,1'b1,1,1,0);
    s1(0,1,1,0, 1,1'b1,1,1,0);
    s1(0,1,0,0, 0,1'b1,1,1,0);
    s1(0,1,1,1, 1,1'b0,1,1,0);
    s1(0,0,0,1, 1,1'b1,0,0,0);

    // Nine-bit frame with a non-zero reset value and enable gaps.
    s9(1,0,0,0, 1,9'b110000001,0,0,0);
    s9(0,1,1,0, 0,9'b110000001,1,0,0);
    s9(0,0,1,0, 0,9'b110000001,1,0,0);
    s9(0,1,0,0, 0,9'b110000001,2,0,0);
    s9(0,1,1,0, 0,9'b110000001,3,0,0);
    s9(0,1,0,0, 0,9'b110000001,4,0,0);
    s9(0,0,0,0, 0,9'b110000001,4,0,0);
    s9(0,1,0,0, 0,9'b110000001,5,0,0);
    s9(0,0,0,1, 0,9'b110000001,5,0,1);
    s9(0,1,1,0, 0,9'b110000001,6,0,0);
    s9(0,1,1,0, 1,9'b110000001,7,0,0);
    s9(0,1,0,0, 1,9'b110000001,8,0,0);
    s9(0,1,1,0, 1,9'b110000001,9,1,0);
    s9(0,0,0,1, 1,9'b101100101,0,0,0);

    @(negedge clk);
    ccff_en = 1'b0;
    commit  = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
